// File: rtl/motion_ctrl_fsm.sv
// motion_ctrl_fsm: wheel-speed command sequencer for the two-wheel drive base.
// Accepts stop/straight/curve/spin commands over valid/ready and drives
// registered sign-magnitude speed codes. Spin moves close on encoder ticks.
// Optional feature macro: MC_RAMP_EN (output slew limiting; absent by default).
module motion_ctrl_fsm #(
    parameter int SPD_W         = 3,
    parameter int ANG_W         = 9,
    parameter int TICK_W        = 10,
    parameter int TICKS_PER_360 = 360,
    parameter int CURVE_SHIFT   = 1,
    parameter int RAMP_PERIOD   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_type,
    input  logic             cmd_dir,
    input  logic [SPD_W-1:0] cmd_speed,
    input  logic [ANG_W-1:0] cmd_angle,
    input  logic             tick_pulse,
    input  logic             abort,
    output logic [SPD_W-1:0] spd_left,
    output logic [SPD_W-1:0] spd_right,
    output logic             busy,
    output logic             done
);

    localparam int MAG_W  = SPD_W - 1;
    localparam int PW0    = ANG_W + $clog2(TICKS_PER_360 + 1);
    localparam int PROD_W = (PW0 > TICK_W) ? PW0 : TICK_W + 1;
    // A non-positive ramp period is a configuration error; refuse commands.
    localparam bit RAMP_OK = (RAMP_PERIOD >= 1);

    typedef enum logic [1:0] {IDLE, DRIVE, CALC, SPIN} state_t;

    state_t            state, state_n;
    logic [SPD_W-1:0]  cl, cr, cl_n, cr_n;          // commanded wheel codes
    logic              done_n;
    logic [TICK_W-1:0] cnt, cnt_n, tgt, tgt_n;
    logic              spin_dir, spin_dir_n;
    logic [MAG_W-1:0]  spin_mag, spin_mag_n;
    logic [ANG_W-1:0]  spin_ang, spin_ang_n;

    logic              settled;
    logic              accept;
    logic [PROD_W-1:0] prod, quot;
    logic [TICK_W-1:0] calc_tgt;
    logic              cnt_hit;
    logic [MAG_W-1:0]  cmd_mag;
    logic [SPD_W-1:0]  inner;

    assign cmd_ready = ((state == IDLE) || (state == DRIVE)) && settled && RAMP_OK;
    assign accept    = cmd_valid & cmd_ready;
    assign busy      = (state == CALC) || (state == SPIN);

    // Spin target in ticks: clamped angle scaled by ticks-per-rev, saturated to counter width.
    always_comb begin
        prod     = PROD_W'(spin_ang) * PROD_W'(TICKS_PER_360);
        quot     = prod / PROD_W'(360);
        calc_tgt = ((quot >> TICK_W) != '0) ? '1 : quot[TICK_W-1:0];
    end

    assign cnt_hit = ({1'b0, cnt} + (TICK_W + 1)'(1)) >= {1'b0, tgt};
    assign cmd_mag = cmd_speed[MAG_W-1:0];
    assign inner   = {cmd_speed[SPD_W-1], cmd_mag >> CURVE_SHIFT};

    // Next-state and next commanded speeds; abort overrides everything.
    always_comb begin
        state_n    = state;
        cl_n       = cl;
        cr_n       = cr;
        done_n     = 1'b0;
        cnt_n      = cnt;
        tgt_n      = tgt;
        spin_dir_n = spin_dir;
        spin_mag_n = spin_mag;
        spin_ang_n = spin_ang;
        if (abort) begin
            state_n = IDLE;
            cl_n    = '0;
            cr_n    = '0;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE, DRIVE: begin
                    if (accept) begin
                        case (cmd_type)
                            2'b00: begin
                                state_n = IDLE;
                                cl_n    = '0;
                                cr_n    = '0;
                            end
                            2'b01: begin
                                state_n = DRIVE;
                                cl_n    = cmd_speed;
                                cr_n    = cmd_speed;
                            end
                            2'b10: begin
                                state_n = DRIVE;
                                cl_n    = cmd_dir ? inner : cmd_speed;
                                cr_n    = cmd_dir ? cmd_speed : inner;
                            end
                            default: begin
                                state_n    = CALC;
                                spin_dir_n = cmd_dir;
                                spin_mag_n = cmd_mag;
                                spin_ang_n = (32'(cmd_angle) > 32'd359) ? ANG_W'(359) : cmd_angle;
                            end
                        endcase
                    end
                end
                CALC: begin
                    cnt_n = '0;
                    tgt_n = calc_tgt;
                    if (calc_tgt == '0) begin
                        state_n = IDLE;
                        cl_n    = '0;
                        cr_n    = '0;
                        done_n  = 1'b1;
                    end else begin
                        state_n = SPIN;
                        cl_n    = {~spin_dir, spin_mag};
                        cr_n    = { spin_dir, spin_mag};
                    end
                end
                SPIN: begin
                    if (tick_pulse) begin
                        cnt_n = (cnt == '1) ? cnt : cnt + TICK_W'(1);
                        if (cnt_hit) begin
                            state_n = IDLE;
                            cl_n    = '0;
                            cr_n    = '0;
                            done_n  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                    cl_n    = '0;
                    cr_n    = '0;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cl       <= '0;
            cr       <= '0;
            done     <= 1'b0;
            cnt      <= '0;
            tgt      <= '0;
            spin_dir <= 1'b0;
            spin_mag <= '0;
            spin_ang <= '0;
        end else begin
            state    <= state_n;
            cl       <= cl_n;
            cr       <= cr_n;
            done     <= done_n;
            cnt      <= cnt_n;
            tgt      <= tgt_n;
            spin_dir <= spin_dir_n;
            spin_mag <= spin_mag_n;
            spin_ang <= spin_ang_n;
        end
    end

`ifdef MC_RAMP_EN
    localparam int RC_W = (RAMP_PERIOD > 1) ? $clog2(RAMP_PERIOD) : 1;

    logic [RC_W-1:0]  rcnt;
    logic [SPD_W-1:0] out_l, out_r;

    // One slew step toward the commanded code. On a direction mismatch the
    // magnitude winds down first and the MSB adopts the target sign as it reaches 0.
    function automatic logic [SPD_W-1:0] ramp_step(input logic [SPD_W-1:0] cur,
                                                   input logic [SPD_W-1:0] cmd);
        logic [MAG_W-1:0] m;
        m = cur[MAG_W-1:0];
        if (cur == cmd) begin
            ramp_step = cur;
        end else if (cur[SPD_W-1] != cmd[SPD_W-1]) begin
            m = (m == '0) ? m : m - MAG_W'(1);
            ramp_step = (m == '0) ? {cmd[SPD_W-1], m} : {cur[SPD_W-1], m};
        end else if (m < cmd[MAG_W-1:0]) begin
            ramp_step = {cur[SPD_W-1], m + MAG_W'(1)};
        end else begin
            ramp_step = {cur[SPD_W-1], m - MAG_W'(1)};
        end
    endfunction

    assign settled   = (out_l == cl) && (out_r == cr);
    assign spd_left  = out_l;
    assign spd_right = out_r;

    // Slew timer: step both wheels once per RAMP_PERIOD clocks while unsettled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_l <= '0;
            out_r <= '0;
            rcnt  <= '0;
        end else if (settled) begin
            rcnt <= '0;
        end else if (rcnt == RC_W'(RAMP_PERIOD - 1)) begin
            out_l <= ramp_step(out_l, cl);
            out_r <= ramp_step(out_r, cr);
            rcnt  <= '0;
        end else begin
            rcnt <= rcnt + RC_W'(1);
        end
    end
`else
    assign settled   = 1'b1;
    assign spd_left  = cl;
    assign spd_right = cr;
`endif

endmodule

// File: tb/tb_motion_ctrl_fsm.sv
// Self-checking bench for motion_ctrl_fsm (default build, MC_RAMP_EN undefined).
// Observed vector per cycle: {spd_left, spd_right, done, busy, cmd_ready}.
module tb_motion_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_type;
    logic       cmd_dir;
    logic [2:0] cmd_speed;
    logic [8:0] cmd_angle;
    logic       tick_pulse;
    logic       abort;
    logic [2:0] spd_left;
    logic [2:0] spd_right;
    logic       busy;
    logic       done;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [8:0]  exp_q[$];

    motion_ctrl_fsm #(
        .SPD_W(3), .ANG_W(9), .TICK_W(10), .TICKS_PER_360(360),
        .CURVE_SHIFT(1), .RAMP_PERIOD(16)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_type(cmd_type), .cmd_dir(cmd_dir), .cmd_speed(cmd_speed),
        .cmd_angle(cmd_angle), .tick_pulse(tick_pulse), .abort(abort),
        .spd_left(spd_left), .spd_right(spd_right), .busy(busy), .done(done)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] t, input logic d,
                         input logic [2:0] s, input logic [8:0] a,
                         input logic tk, input logic ab, input logic r);
        cmd_valid  = v;
        cmd_type   = t;
        cmd_dir    = d;
        cmd_speed  = s;
        cmd_angle  = a;
        tick_pulse = tk;
        abort      = ab;
        rst        = r;
    endtask

    task automatic test_reset();
        logic [8:0] e, got;
        for (int i = 0; i < 3; i++) begin
            if (i < 2) begin
                drive(1'b1, 2'b01, 1'b0, 3'b111, 9'd0, 1'b1, 1'b0, 1'b1);
                exp_q.push_back(9'b000_000_001);
                clk_step();
            end else begin
                drive(1'b0, 2'b00, 1'b0, 3'b000, 9'd0, 1'b0, 1'b0, 1'b0);
                exp_q.push_back(9'b000_000_001);
                #1;
            end
            got = {spd_left, spd_right, done, busy, cmd_ready};
            e   = exp_q.pop_front();
            n_checks++;
            if (got !== e) $display("FAIL reset[%0d]: got %b expected %b", i, got, e);
            else n_pass++;
        end
    endtask

    task automatic test_straight();
        logic [8:0] e, got;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: begin drive(1, 2'b01, 0, 3'b111, 0, 0, 0, 0); e = {3'b111, 3'b111, 3'b001}; end
                1: begin drive(0, 2'b00, 0, 3'b000, 0, 0, 0, 0); e = {3'b111, 3'b111, 3'b001}; end
                2: begin drive(1, 2'b00, 0, 3'b000, 0, 0, 0, 0); e = {3'b000, 3'b000, 3'b001}; end
                3: begin drive(1, 2'b01, 1, 3'b010, 0, 0, 0, 0); e = {3'b010, 3'b010, 3'b001}; end
                default: begin drive(1, 2'b00, 0, 3'b000, 0, 0, 0, 0); e = 9'b000_000_001; end
            endcase
            exp_q.push_back(e);
            clk_step();
            got = {spd_left, spd_right, done, busy, cmd_ready};
            e   = exp_q.pop_front();
            n_checks++;
            if (got !== e) $display("FAIL straight[%0d]: got %b expected %b", i, got, e);
            else n_pass++;
        end
    endtask

    task automatic test_curve();
        logic [8:0] e, got;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: begin drive(1, 2'b10, 1, 3'b111, 0, 0, 0, 0); e = {3'b101, 3'b111, 3'b001}; end
                1: begin drive(1, 2'b10, 0, 3'b111, 0, 0, 0, 0); e = {3'b111, 3'b101, 3'b001}; end
                2: begin drive(1, 2'b10, 1, 3'b011, 0, 0, 0, 0); e = {3'b001, 3'b011, 3'b001}; end
                3: begin drive(1, 2'b10, 0, 3'b110, 0, 0, 0, 0); e = {3'b110, 3'b101, 3'b001}; end
                default: begin drive(1, 2'b00, 0, 3'b000, 0, 0, 0, 0); e = 9'b000_000_001; end
            endcase
            exp_q.push_back(e);
            clk_step();
            got = {spd_left, spd_right, done, busy, cmd_ready};
            e   = exp_q.pop_front();
            n_checks++;
            if (got !== e) $display("FAIL curve[%0d]: got %b expected %b", i, got, e);
            else n_pass++;
        end
    endtask

    // mode 0: run to completion; 1: abort on the final tick; 2: rst on tick 40.
    task automatic test_spin(input logic d, input logic [2:0] sp, input logic [8:0] ang,
                             input int unsigned tgt, input int unsigned mode,
                             input logic [5:0] prev);
        logic [8:0]  e, got;
        logic [2:0]  sl, sr;
        int unsigned tk  = 0;
        int unsigned i   = 0;
        bit          fin = 0;
        sl = d ? {1'b0, sp[1:0]} : {1'b1, sp[1:0]};
        sr = d ? {1'b1, sp[1:0]} : {1'b0, sp[1:0]};
        while (!fin && i < 1000) begin
            drive(0, 2'b00, 0, 3'b000, 0, 0, 0, 0);
            if (i == 0) begin
                drive(1, 2'b11, d, sp, ang, 0, 0, 0);
                e = {prev, 3'b010};
            end else if (i == 1) begin
                tick_pulse = 1'b1;                  // must be ignored in CALC
                e = {sl, sr, 3'b010};
            end else begin
                tick_pulse = (i % 10 != 5);
                if (i % 7 == 3) begin               // command offered while busy
                    cmd_valid = 1'b1;
                    cmd_type  = 2'b01;
                    cmd_speed = 3'b111;
                end
                if (tick_pulse) tk++;
                if (mode == 2 && tick_pulse && tk == 40) begin
                    rst = 1'b1;
                    e   = 9'b000_000_001;
                    fin = 1;
                end else if (tick_pulse && tk == tgt) begin
                    if (mode == 1) begin
                        abort = 1'b1;
                        e     = 9'b000_000_001;
                    end else begin
                        e = 9'b000_000_101;
                    end
                    fin = 1;
                end else begin
                    e = {sl, sr, 3'b010};
                end
            end
            exp_q.push_back(e);
            clk_step();
            got = {spd_left, spd_right, done, busy, cmd_ready};
            e   = exp_q.pop_front();
            n_checks++;
            if (got !== e) $display("FAIL spin m%0d ang%0d step %0d: got %b expected %b",
                                    mode, ang, i, got, e);
            else n_pass++;
            i++;
        end
        if (!fin) begin
            n_checks++;
            $display("FAIL spin m%0d timeout: got %0d ticks expected %0d", mode, tk, tgt);
        end
        drive(0, 2'b00, 0, 3'b000, 0, 0, 0, 0);
        exp_q.push_back(9'b000_000_001);
        clk_step();
        got = {spd_left, spd_right, done, busy, cmd_ready};
        e   = exp_q.pop_front();
        n_checks++;
        if (got !== e) $display("FAIL spin m%0d after: got %b expected %b", mode, got, e);
        else n_pass++;
    endtask

    task automatic test_spin_zero();
        logic [8:0] e, got;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: begin drive(1, 2'b01, 0, 3'b101, 0, 0, 0, 0); e = {3'b101, 3'b101, 3'b001}; end
                1: begin drive(1, 2'b11, 1, 3'b011, 0, 0, 0, 0); e = {3'b101, 3'b101, 3'b010}; end
                2: begin drive(0, 2'b00, 0, 3'b000, 0, 1, 0, 0); e = 9'b000_000_101; end
                default: begin drive(0, 2'b00, 0, 3'b000, 0, 0, 0, 0); e = 9'b000_000_001; end
            endcase
            exp_q.push_back(e);
            clk_step();
            got = {spd_left, spd_right, done, busy, cmd_ready};
            e   = exp_q.pop_front();
            n_checks++;
            if (got !== e) $display("FAIL spin_zero[%0d]: got %b expected %b", i, got, e);
            else n_pass++;
        end
    endtask

    task automatic test_abort();
        logic [8:0] e, got;
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: begin drive(1, 2'b01, 0, 3'b111, 0, 0, 0, 0); e = {3'b111, 3'b111, 3'b001}; end
                1: begin drive(1, 2'b01, 0, 3'b011, 0, 0, 1, 0); e = 9'b000_000_001; end
                2: begin drive(1, 2'b10, 1, 3'b111, 0, 0, 0, 0); e = {3'b101, 3'b111, 3'b001}; end
                3: begin drive(1, 2'b11, 1, 3'b010, 9'd90, 0, 1, 0); e = 9'b000_000_001; end
                4: begin drive(1, 2'b11, 1, 3'b010, 9'd90, 0, 0, 0); e = 9'b000_000_010; end
                default: begin drive(0, 2'b00, 0, 3'b000, 0, 1, 1, 0); e = 9'b000_000_001; end
            endcase
            exp_q.push_back(e);
            clk_step();
            got = {spd_left, spd_right, done, busy, cmd_ready};
            e   = exp_q.pop_front();
            n_checks++;
            if (got !== e) $display("FAIL abort[%0d]: got %b expected %b", i, got, e);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] e, got;
        for (int i = 0; i < 7; i++) begin
            case (i)
                0: begin drive(1, 2'b01, 0, 3'b111, 0, 0, 0, 0); e = {3'b111, 3'b111, 3'b001}; end
                1: begin drive(1, 2'b10, 1, 3'b110, 0, 0, 0, 0); e = {3'b101, 3'b110, 3'b001}; end
                2: begin drive(1, 2'b11, 1, 3'b001, 9'd1, 0, 0, 0); e = {3'b101, 3'b110, 3'b010}; end
                3: begin drive(0, 2'b00, 0, 3'b000, 0, 0, 0, 0); e = {3'b001, 3'b101, 3'b010}; end
                4: begin drive(0, 2'b00, 0, 3'b000, 0, 1, 0, 0); e = 9'b000_000_101; end
                5: begin drive(1, 2'b01, 0, 3'b011, 0, 0, 0, 0); e = {3'b011, 3'b011, 3'b001}; end
                default: begin drive(1, 2'b00, 0, 3'b000, 0, 0, 0, 0); e = 9'b000_000_001; end
            endcase
            exp_q.push_back(e);
            clk_step();
            got = {spd_left, spd_right, done, busy, cmd_ready};
            e   = exp_q.pop_front();
            n_checks++;
            if (got !== e) $display("FAIL back_to_back[%0d]: got %b expected %b", i, got, e);
            else n_pass++;
        end
    endtask

    // Scenario sequence.
    initial begin
        drive(0, 2'b00, 0, 3'b000, 0, 0, 0, 1);
        test_reset();
        test_straight();
        test_curve();
        test_spin(1'b0, 3'b010, 9'd90, 90, 0, 6'b000_000);
        test_spin_zero();
        test_spin(1'b1, 3'b011, 9'd400, 359, 0, 6'b000_000);
        test_spin(1'b0, 3'b111, 9'd90, 90, 1, 6'b000_000);
        test_spin(1'b1, 3'b010, 9'd90, 90, 2, 6'b000_000);
        test_spin(1'b0, 3'b000, 9'd10, 10, 0, 6'b000_000);
        test_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
